// File: rtl/filter_pkg.sv
// Shared types and constants for the binary 3x3 median (majority) filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package filter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam int            WIN_SIZE       = 3;
    localparam int            DEF_THRESH     = 5;
    localparam logic [7:0]    DEF_BORDER_VAL = 8'h00;

    // Number of set bits in a flattened 3x3 window.
    function automatic logic [3:0] popcount9(input logic [8:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/line_buf_1b.sv
// One-line 1-bit delay memory with separate write and read addresses.
// Latency: read data registered, valid 1 cycle after an enabled access.
// Backpressure: none; memory and read register only move when en is high.
// Ports: clk/rst_n, en, wr_addr/wr_dat, rd_addr, rd_dat (registered).
module line_buf_1b #(
    parameter int DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic                     wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rd_dat
);

    logic mem_q [DEPTH];
    logic rd_dat_q;
    logic rd_dat_d;

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (en) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    // Storage array is not reset: stale contents only ever reach border centres.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= 1'b0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/filter_median_bin.sv
// Binary 3x3 majority filter over a raster stream; border centres forced to BORDER_VAL.
// Latency: centre (r,c) emitted 1 cycle after pixel r*IMG_W+c+IMG_W+1 (or its flush pixel).
// Backpressure: in_ready low only while flushing IMG_W+1 trailing zeros; output has none.
// Ports: clk_f_nios, rst_f_nios_n, in_valid/in_ready/in_sof/in_pixel, out_valid/out_sof/out_pixel.
// Option: FILTER_MEDIAN_CNT_EN adds out_cnt (window ones count, 0 on border centres).
module filter_median_bin
    import filter_pkg::*;
#(
    parameter int         IMG_W      = 640,
    parameter int         IMG_H      = 480,
    parameter int         BIT_SEL    = 0,
    parameter int         THRESH     = DEF_THRESH,
    parameter logic [7:0] BORDER_VAL = DEF_BORDER_VAL
) (
    input  logic       clk_f_nios,
    input  logic       rst_f_nios_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    output logic       out_sof,
    output logic [7:0] out_pixel
`ifdef FILTER_MEDIAN_CNT_EN
    ,
    output logic [3:0] out_cnt
`endif
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int LEAD_W = $clog2(IMG_W + 2);
    localparam int FL_W   = $clog2(IMG_W + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [LEAD_W-1:0] LEAD_FULL = LEAD_W'(IMG_W + 1);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(IMG_W);

    typedef logic [WIN_SIZE-1:0][WIN_SIZE-1:0] win_t;   // [row][col], row 0 = oldest line, col 2 = newest

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;       // column of the next push
    logic [ROW_W-1:0]   row_q, row_d;
    logic [LEAD_W-1:0]  lead_q, lead_d;     // pushes seen so far, saturating at IMG_W+1
    logic [FL_W-1:0]    flush_q, flush_d;
    logic [COL_W-1:0]   ccol_q, ccol_d;     // centre position of the next emitted output
    logic [ROW_W-1:0]   crow_q, crow_d;
    win_t               win_q, win_d, win_new;
    logic               out_valid_q, out_valid_d;
    logic               out_sof_q, out_sof_d;
    logic [7:0]         out_pixel_q, out_pixel_d;

    logic               accept, sof_acc, run_acc, flush_push, push;
    logic [COL_W-1:0]   push_col, next_col;
    logic               new_bit, lb0_rd, lb1_rd, border;
    logic [WIN_SIZE-1:0] col_new;
    logic [3:0]         win_cnt;
    logic               unused_in_bits;

    assign unused_in_bits = ^in_pixel;

    assign in_ready   = (state_q != S_FLUSH);
    assign accept     = in_valid & in_ready;
    assign sof_acc    = accept & in_sof;
    assign run_acc    = accept & ~in_sof & (state_q == S_RUN);
    assign flush_push = (state_q == S_FLUSH);
    assign push       = sof_acc | run_acc | flush_push;

    // A sof pixel is always column 0 regardless of where the aborted frame stopped.
    assign push_col = sof_acc ? '0 : col_q;
    assign next_col = (push_col == COL_LAST) ? '0 : push_col + COL_W'(1);
    assign new_bit  = flush_push ? 1'b0 : in_pixel[BIT_SEL];

    // Reads are issued one push ahead (next column) so the registered read data
    // is already waiting when that column's pixel arrives.
    line_buf_1b #(.DEPTH(IMG_W)) u_lb0 (
        .clk     (clk_f_nios),
        .rst_n   (rst_f_nios_n),
        .en      (push),
        .wr_addr (push_col),
        .wr_dat  (new_bit),
        .rd_addr (next_col),
        .rd_dat  (lb0_rd)
    );

    line_buf_1b #(.DEPTH(IMG_W)) u_lb1 (
        .clk     (clk_f_nios),
        .rst_n   (rst_f_nios_n),
        .en      (push),
        .wr_addr (push_col),
        .wr_dat  (lb0_rd),
        .rd_addr (next_col),
        .rd_dat  (lb1_rd)
    );

    always_comb begin
        col_new = {new_bit, lb0_rd, lb1_rd};
        win_new = win_q;
        for (int r = 0; r < WIN_SIZE; r++) begin
            win_new[r] = {col_new[r], win_q[r][WIN_SIZE-1:1]};
        end
    end

    assign win_cnt = popcount9(win_new);
    assign border  = (ccol_q == '0) || (ccol_q == COL_LAST) ||
                     (crow_q == '0) || (crow_q == ROW_LAST);

`ifdef FILTER_MEDIAN_CNT_EN
    logic [3:0] out_cnt_q, out_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        lead_d      = lead_q;
        flush_d     = flush_q;
        ccol_d      = ccol_q;
        crow_d      = crow_q;
        win_d       = win_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_pixel_d = out_pixel_q;
`ifdef FILTER_MEDIAN_CNT_EN
        out_cnt_d   = out_cnt_q;
`endif
        if (push) begin
            win_d = win_new;
            col_d = next_col;
        end

        if (sof_acc) begin
            // New frame (from idle or aborting a running one): pending centres are dropped.
            state_d = S_RUN;
            row_d   = '0;
            lead_d  = LEAD_W'(1);
            ccol_d  = '0;
            crow_d  = '0;
        end else begin
            if (run_acc && (push_col == COL_LAST)) begin
                if (row_q == ROW_LAST) begin
                    state_d = S_FLUSH;
                    flush_d = '0;
                    row_d   = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            if (flush_push) begin
                flush_d = flush_q + FL_W'(1);
                if (flush_q == FL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            if (push) begin
                if (lead_q != LEAD_FULL) begin
                    lead_d = lead_q + LEAD_W'(1);
                end else begin
                    out_valid_d = 1'b1;
                    out_sof_d   = (ccol_q == '0) && (crow_q == '0);
                    out_pixel_d = border ? BORDER_VAL :
                                  ((win_cnt >= 4'(THRESH)) ? 8'hFF : 8'h00);
`ifdef FILTER_MEDIAN_CNT_EN
                    out_cnt_d   = border ? 4'd0 : win_cnt;
`endif
                    if (ccol_q == COL_LAST) begin
                        ccol_d = '0;
                        crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + ROW_W'(1);
                    end else begin
                        ccol_d = ccol_q + COL_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_f_nios or negedge rst_f_nios_n) begin
        if (!rst_f_nios_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            lead_q      <= '0;
            flush_q     <= '0;
            ccol_q      <= '0;
            crow_q      <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_pixel_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lead_q      <= lead_d;
            flush_q     <= flush_d;
            ccol_q      <= ccol_d;
            crow_q      <= crow_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_pixel_q <= out_pixel_d;
        end
    end

`ifdef FILTER_MEDIAN_CNT_EN
    always_ff @(posedge clk_f_nios or negedge rst_f_nios_n) begin
        if (!rst_f_nios_n) begin
            out_cnt_q <= 4'd0;
        end else begin
            out_cnt_q <= out_cnt_d;
        end
    end
    assign out_cnt = out_cnt_q;
`endif

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_filter_median_bin.sv
// Directed bench for filter_median_bin at IMG_W=8, IMG_H=6.
// Latency: n/a.
// Backpressure: n/a.
module tb_filter_median_bin;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'h00;
    logic       out_valid;
    logic       out_sof;
    logic [7:0] out_pixel;
`ifdef FILTER_MEDIAN_CNT_EN
    logic [3:0] out_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    bit         img [N];
    logic [7:0] obs_pix [2048];
    bit         obs_sof [2048];
    logic [3:0] obs_cnt [2048];
    int         obs_n = 0;

    filter_median_bin #(.IMG_W(W), .IMG_H(H)) dut (
        .clk_f_nios   (clk),
        .rst_f_nios_n (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_pixel     (in_pixel),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_pixel    (out_pixel)
`ifdef FILTER_MEDIAN_CNT_EN
        ,
        .out_cnt      (out_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid === 1'b1 && obs_n < 2048) begin
            obs_pix[obs_n] <= out_pixel;
            obs_sof[obs_n] <= out_sof;
`ifdef FILTER_MEDIAN_CNT_EN
            obs_cnt[obs_n] <= out_cnt;
`else
            obs_cnt[obs_n] <= 4'd0;
`endif
            obs_n <= obs_n + 1;
        end
    end

    // Unused bits of in_pixel are driven opposite to the data bit to prove only bit 0 matters.
    task automatic drive_px(input int idx);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = (idx == 0);
        in_pixel = img[idx] ? 8'h01 : 8'hFE;
    endtask

    task automatic fill(input bit v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic send_frame(input bit gap, output int rdy_low);
        for (int i = 0; i < N; i++) begin
            if (gap && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end
            drive_px(i);
        end
        rdy_low = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
            if (in_ready === 1'b0) rdy_low++;
            else if (rdy_low > 0) break;
        end
    endtask

    task automatic wait_outputs(input int base, input int want);
        for (int k = 0; k < 200 && (obs_n - base) < want; k++) @(posedge clk);
        repeat (12) @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_pixel = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (out_sof !== 1'b0) $display("FAIL reset_out_sof: got %b want 0", out_sof); else n_pass++;
        n_chk++; if (out_pixel !== 8'h00) $display("FAIL reset_out_pixel: got %h want 00", out_pixel); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (obs_n !== 0) $display("FAIL reset_no_strobe: got %0d want 0", obs_n); else n_pass++;
    endtask

    task automatic test_all_ones;
        int base, rl, r, c;
        logic [7:0] exp;
        fill(1'b1);
        base = obs_n;
        send_frame(1'b0, rl);
        wait_outputs(base, N);
        n_chk++; if (obs_n - base !== N) $display("FAIL ones_count: got %0d want %0d", obs_n - base, N); else n_pass++;
        n_chk++; if (rl !== W + 1) $display("FAIL ones_flush_len: got %0d want %0d", rl, W + 1); else n_pass++;
        for (int i = 0; i < N; i++) begin
            r = i / W; c = i % W;
            exp = (r >= 1 && r <= 4 && c >= 1 && c <= 6) ? 8'hFF : 8'h00;
            n_chk++; if (obs_pix[base+i] !== exp) $display("FAIL ones_pix[%0d]: got %h want %h", i, obs_pix[base+i], exp); else n_pass++;
            n_chk++; if (obs_sof[base+i] !== (i == 0)) $display("FAIL ones_sof[%0d]: got %b want %b", i, obs_sof[base+i], (i == 0)); else n_pass++;
        end
    endtask

    task automatic test_single_one;
        int base, rl, r, c;
        logic [3:0] exp_cnt;
        fill(1'b0);
        img[2*W+3] = 1'b1;
        base = obs_n;
        send_frame(1'b0, rl);
        wait_outputs(base, N);
        n_chk++; if (obs_n - base !== N) $display("FAIL single_count: got %0d want %0d", obs_n - base, N); else n_pass++;
        for (int i = 0; i < N; i++) begin
            r = i / W; c = i % W;
            n_chk++; if (obs_pix[base+i] !== 8'h00) $display("FAIL single_pix[%0d]: got %h want 00", i, obs_pix[base+i]); else n_pass++;
            exp_cnt = (r >= 1 && r <= 3 && c >= 2 && c <= 4) ? 4'd1 : 4'd0;
`ifdef FILTER_MEDIAN_CNT_EN
            n_chk++; if (obs_cnt[base+i] !== exp_cnt) $display("FAIL single_cnt[%0d]: got %0d want %0d", i, obs_cnt[base+i], exp_cnt); else n_pass++;
`else
            if (exp_cnt > 4'd1) $display("note: unexpected count model value");
`endif
        end
    endtask

    task automatic test_threshold;
        int base, rl;
        fill(1'b0);
        img[1*W+1] = 1'b1; img[1*W+2] = 1'b1; img[1*W+3] = 1'b1;
        img[2*W+1] = 1'b1; img[2*W+2] = 1'b1;
        base = obs_n;
        send_frame(1'b0, rl);
        wait_outputs(base, N);
        n_chk++; if (obs_pix[base+2*W+2] !== 8'hFF) $display("FAIL thr5_c22: got %h want FF", obs_pix[base+2*W+2]); else n_pass++;
        n_chk++; if (obs_pix[base+1*W+2] !== 8'hFF) $display("FAIL thr5_c12: got %h want FF", obs_pix[base+1*W+2]); else n_pass++;
        n_chk++; if (obs_pix[base+2*W+1] !== 8'h00) $display("FAIL thr4_c21: got %h want 00", obs_pix[base+2*W+1]); else n_pass++;
        n_chk++; if (obs_pix[base+2*W+3] !== 8'h00) $display("FAIL thr3_c23: got %h want 00", obs_pix[base+2*W+3]); else n_pass++;
        img[1*W+3] = 1'b0;
        base = obs_n;
        send_frame(1'b0, rl);
        wait_outputs(base, N);
        n_chk++; if (obs_pix[base+2*W+2] !== 8'h00) $display("FAIL thr4_c22: got %h want 00", obs_pix[base+2*W+2]); else n_pass++;
        n_chk++; if (obs_pix[base+1*W+2] !== 8'h00) $display("FAIL thr4_c12: got %h want 00", obs_pix[base+1*W+2]); else n_pass++;
    endtask

    task automatic test_gaps;
        int base, rl, r, c;
        logic [7:0] exp;
        fill(1'b1);
        base = obs_n;
        send_frame(1'b1, rl);
        wait_outputs(base, N);
        n_chk++; if (obs_n - base !== N) $display("FAIL gaps_count: got %0d want %0d", obs_n - base, N); else n_pass++;
        n_chk++; if (rl !== 9) $display("FAIL gaps_ready_low: got %0d want 9", rl); else n_pass++;
        for (int i = 0; i < N; i++) begin
            r = i / W; c = i % W;
            exp = (r >= 1 && r <= 4 && c >= 1 && c <= 6) ? 8'hFF : 8'h00;
            n_chk++; if (obs_pix[base+i] !== exp) $display("FAIL gaps_pix[%0d]: got %h want %h", i, obs_pix[base+i], exp); else n_pass++;
        end
        n_chk++; if (obs_sof[base] !== 1'b1) $display("FAIL gaps_sof: got %b want 1", obs_sof[base]); else n_pass++;
    endtask

    task automatic test_abort;
        int base0, base, r, c;
        logic [7:0] exp;
        fill(1'b1);
        base0 = obs_n;
        for (int i = 0; i < 20; i++) drive_px(i);
        drive_px(0);
        @(posedge clk);
        #1;
        base = obs_n;
        n_chk++; if (base - base0 !== 11) $display("FAIL abort_pre_count: got %0d want 11", base - base0); else n_pass++;
        for (int i = 1; i < N; i++) drive_px(i);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        wait_outputs(base, N);
        n_chk++; if (obs_n - base !== N) $display("FAIL abort_count: got %0d want %0d", obs_n - base, N); else n_pass++;
        n_chk++; if (obs_sof[base] !== 1'b1) $display("FAIL abort_first_sof: got %b want 1", obs_sof[base]); else n_pass++;
        for (int i = 0; i < N; i++) begin
            r = i / W; c = i % W;
            exp = (r >= 1 && r <= 4 && c >= 1 && c <= 6) ? 8'hFF : 8'h00;
            n_chk++; if (obs_pix[base+i] !== exp) $display("FAIL abort_pix[%0d]: got %h want %h", i, obs_pix[base+i], exp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int base, rl, r, c;
        logic [7:0] exp;
        fill(1'b1);
        for (int i = 0; i < 30; i++) drive_px(i);
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = obs_n;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_pixel = 8'h01;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        n_chk++; if (obs_n !== base) $display("FAIL rstmid_silent: got %0d strobes want 0", obs_n - base); else n_pass++;
        base = obs_n;
        send_frame(1'b0, rl);
        wait_outputs(base, N);
        n_chk++; if (obs_n - base !== N) $display("FAIL rstmid_count: got %0d want %0d", obs_n - base, N); else n_pass++;
        n_chk++; if (obs_sof[base] !== 1'b1) $display("FAIL rstmid_sof: got %b want 1", obs_sof[base]); else n_pass++;
        for (int i = 0; i < N; i++) begin
            r = i / W; c = i % W;
            exp = (r >= 1 && r <= 4 && c >= 1 && c <= 6) ? 8'hFF : 8'h00;
            n_chk++; if (obs_pix[base+i] !== exp) $display("FAIL rstmid_pix[%0d]: got %h want %h", i, obs_pix[base+i], exp); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_one();
        test_threshold();
        test_gaps();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/filter_median_bin.md
FILTER_MEDIAN_BIN -- requirements
Module: filter_median_bin

Interface
REQ-001 SHALL have parameter IMG_W, default 640, meaning pixels per line (minimum 4).
REQ-002 SHALL have parameter IMG_H, default 480, meaning lines per frame (minimum 3).
REQ-003 SHALL have parameter BIT_SEL, default 0, meaning the input bit treated as the binary pixel.
REQ-004 SHALL have parameter THRESH, default 5, meaning the minimum count of ones in the 3x3 window (range 1..9) for a white output.
REQ-005 SHALL have parameter BORDER_VAL, default 8'h00, meaning the output value for border centre pixels.
REQ-006 Ports: clk_f_nios  in  1  single clock; all logic on its rising edge.
REQ-007 Ports: rst_f_nios_n  in  1  reset, asynchronous, active-low.
REQ-008 Ports: in_valid  in  1  input pixel present.
REQ-009 Ports: in_ready  out  1  block accepts a pixel this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-010 Ports: in_sof  in  1  qualifies the accepted pixel as the first pixel (0,0) of a frame.
REQ-011 Ports: in_pixel  in  8  raster-order pixel; only bit BIT_SEL is used.
REQ-012 Ports: out_valid  out  1  single-cycle strobe; out_pixel is valid this cycle (no backpressure).
REQ-013 Ports: out_sof  out  1  high with out_valid for centre pixel (0,0).
REQ-014 Ports: out_pixel  out  8  filtered pixel: 8'hFF, 8'h00 or BORDER_VAL.

Function
REQ-015 SHALL contain an FSM with states S_IDLE, S_RUN and S_FLUSH, encoded with the enum in filter_pkg.
- S_IDLE: in_ready=1; non-sof pixels are discarded. An accepted sof pixel starts the frame and moves the FSM to S_RUN.
- S_RUN: in_ready=1. Acceptance of pixel (IMG_H-1, IMG_W-1) moves the FSM to S_FLUSH.
- S_FLUSH: in_ready=0. The block internally generates IMG_W+1 zero pixels, one per cycle, then moves to S_IDLE.
REQ-016 SHALL track the column (0..IMG_W-1) and row (0..IMG_H-1) of accepted pixels; the column wraps to 0 and the row increments at IMG_W-1.
REQ-017 SHALL hold two 1-bit line buffers of depth IMG_W plus a 3x3 bit window, updated only on an accepted or flush pixel.
REQ-018 For centre (r,c), the output SHALL be produced 1 cycle after accepting the pixel at linear index r*IMG_W+c+IMG_W+1, or after the corresponding flush pixel.
REQ-019 SHALL produce exactly IMG_W*IMG_H out_valid strobes per completed frame, in raster order.
REQ-020 Border centres (r=0, r=IMG_H-1, c=0, c=IMG_W-1) SHALL output BORDER_VAL; window wrap across lines is never used.
REQ-021 For interior centres, the block SHALL compute a 4-bit count of ones over the 9 window bits and output 8'hFF if count>=THRESH, else 8'h00.
REQ-022 Gaps in in_valid SHALL only stall the pipeline and SHALL NOT alter the output values or their order.
REQ-023 A sof accepted in S_RUN SHALL abort the current frame: counters restart at (0,0), pending outputs of the aborted frame are dropped, and the new frame proceeds normally.
REQ-024 in_sof is ignored while in_ready=0.

Reset
REQ-025 While rst_f_nios_n=0, the block SHALL hold state S_IDLE, counters 0, window and line-buffer read registers 0, out_valid=0, out_sof=0, out_pixel=8'h00, and in_ready=1.
REQ-026 Reset asserted mid-frame or mid-flush SHALL discard the frame; no out_valid strobe occurs until a new sof is accepted.

Configuration
REQ-027 With macro FILTER_MEDIAN_CNT_EN defined, the block SHALL add output port out_cnt (4 bits), carrying the window count aligned with out_valid; border centres report 0.
REQ-028 Without FILTER_MEDIAN_CNT_EN, the out_cnt port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-029 filter_pkg SHALL hold the FSM state enum, the window size constant (3), and the default THRESH and BORDER_VAL values.
REQ-030 The line buffer SHALL be a sub-module line_buf_1b (parameter DEPTH; 1-bit write/read with enable; read latency 1), instantiated twice.

Verification (IMG_W=8, IMG_H=6, defaults otherwise)
REQ-031 All-ones frame -> 48 strobes; the 24 interior centres (rows 1-4, cols 1-6) give 8'hFF; the 24 border centres give 8'h00.
REQ-032 Single 1 at (2,3) in an all-zero frame -> all 48 outputs 8'h00; with FILTER_MEDIAN_CNT_EN, out_cnt=1 at the 9 centres whose window covers (2,3).
REQ-033 Threshold: 5 ones in the window of (2,2) -> 8'hFF at (2,2); same frame with one of them cleared (4 ones) -> 8'h00.
REQ-034 All-ones frame with in_valid low on every other cycle -> output sequence identical to REQ-031; in_ready=0 for exactly 9 cycles after the last pixel.
REQ-035 sof re-asserted at pixel 20 -> no aborted-frame outputs after the restart; out_sof accompanies the first strobe of the new frame; the new frame matches REQ-031.
REQ-036 rst_f_nios_n pulsed low at pixel 30 -> out_valid=0 immediately; no output until the next sof; the next frame matches REQ-031.
